// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared state type and constants for the SD SPI command engine.
package sd_spi_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_PRE, S_SEND, S_POLL, S_RESP, S_POST, S_DONE} sd_state_t;
    localparam logic [7:0] SD_IDLE_BYTE   = 8'hFF;
    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam logic [2:0] RESP_EXTRA_MAX = 3'd4;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: combinational CRC7 (x^7+x^3+1, init 0) over the 40 command bits, MSB first.
module sd_crc7
    import sd_spi_pkg::*;
(
    input  logic [39:0] data,
    output logic [6:0]  crc
);
    always_comb begin
        crc = '0;
        for (int i = 39; i >= 0; i--)
            crc = {crc[5:0], 1'b0} ^ ((data[i] ^ crc[6]) ? CRC7_POLY : 7'h00);
    end
endmodule

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: frames one SD command, feeds it to the SPI byte shifter,
// polls for R1, gathers trailing response bytes and drives chip select.
module sd_spi_cmd_engine
    import sd_spi_pkg::*;
#(
    parameter int NCR_MAX     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        MasterCLK,
    input  logic        Reset_n,
    input  logic        Cmd_Start,
    input  logic [5:0]  Cmd_Index,
    input  logic [31:0] Cmd_Arg,
    input  logic [2:0]  Resp_Extra,
    output logic        Busy,
    output logic        Done,
    output logic        Timeout,
    output logic [7:0]  Resp_R1,
    output logic [31:0] Resp_Data,
    output logic [7:0]  OutputData,
    output logic        SPI_Enable,
    output logic        SD_CS,
    input  logic [7:0]  InputData,
    input  logic        DataClk
);
    localparam int PW = $clog2(NCR_MAX + 1);
    sd_state_t state, state_nx;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic dclk_prev, byte_tick;
    logic [5:0] idx, idx_nx;
    logic [31:0] arg, arg_nx, data_nx;
    logic [2:0] extra, extra_nx, byte_cnt, byte_cnt_nx, cnt_sel;
    logic [PW-1:0] poll, poll_nx;
    logic [6:0] crc, crc_nx, crc_calc;
    logic [7:0] out_nx, r1_nx, cmd_byte;
    logic en_nx, cs_nx, to_nx;
    sd_crc7 u_crc (.data({2'b01, Cmd_Index, Cmd_Arg}), .crc(crc_calc));
    assign byte_tick = dclk_sync[SYNC_STAGES-1] & ~dclk_prev;
    assign Busy = (state != S_IDLE) && (state != S_DONE);
    assign Done = (state == S_DONE);
    assign cnt_sel = (state == S_PRE) ? 3'd0 : byte_cnt + 3'd1;
    always_comb begin
        case (cnt_sel)
            3'd0:    cmd_byte = {2'b01, idx};
            3'd1:    cmd_byte = arg[31:24];
            3'd2:    cmd_byte = arg[23:16];
            3'd3:    cmd_byte = arg[15:8];
            3'd4:    cmd_byte = arg[7:0];
            default: cmd_byte = {crc, 1'b1};
        endcase
    end
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        arg_nx      = arg;
        extra_nx    = extra;
        crc_nx      = crc;
        byte_cnt_nx = byte_cnt;
        poll_nx     = poll;
        out_nx      = OutputData;
        en_nx       = SPI_Enable;
        cs_nx       = SD_CS;
        to_nx       = Timeout;
        r1_nx       = Resp_R1;
        data_nx     = Resp_Data;
        case (state)
            S_IDLE: if (Cmd_Start) begin
                idx_nx   = Cmd_Index;
                arg_nx   = Cmd_Arg;
                crc_nx   = crc_calc;
                extra_nx = (Resp_Extra > RESP_EXTRA_MAX) ? RESP_EXTRA_MAX : Resp_Extra;
                out_nx   = SD_IDLE_BYTE;
                to_nx    = 1'b0;
                r1_nx    = SD_IDLE_BYTE;
                data_nx  = '0;
                state_nx = S_ALIGN;
            end
            // enabling the shifter only on a byte strobe keeps SCLK bursts byte-aligned
            S_ALIGN: if (byte_tick) begin
                en_nx    = 1'b1;
                cs_nx    = 1'b0;
                state_nx = S_PRE;
            end
            S_PRE: if (byte_tick) begin
                out_nx      = cmd_byte;
                byte_cnt_nx = 3'd0;
                state_nx    = S_SEND;
            end
            S_SEND: if (byte_tick && byte_cnt >= 3'd5) begin
                out_nx   = SD_IDLE_BYTE;
                poll_nx  = '0;
                state_nx = S_POLL;
            end else if (byte_tick) begin
                out_nx      = cmd_byte;
                byte_cnt_nx = cnt_sel;
            end
            S_POLL: if (byte_tick && !InputData[7]) begin
                r1_nx       = InputData;
                byte_cnt_nx = 3'd0;
                state_nx    = (extra == 3'd0) ? S_POST : S_RESP;
            end else if (byte_tick && poll >= PW'(NCR_MAX - 1)) begin
                to_nx    = 1'b1;
                r1_nx    = SD_IDLE_BYTE;
                state_nx = S_POST;
            end else if (byte_tick) begin
                poll_nx = poll + PW'(1);
            end
            S_RESP: if (byte_tick) begin
                data_nx     = Resp_Data | ({InputData, 24'h0} >> {byte_cnt, 3'b000});
                byte_cnt_nx = byte_cnt + 3'd1;
                state_nx    = (byte_cnt_nx >= extra) ? S_POST : S_RESP;
            end
            S_POST: if (byte_tick) begin
                en_nx    = 1'b0;
                cs_nx    = 1'b1;
                state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            dclk_sync  <= '0;
            dclk_prev  <= 1'b0;
            idx        <= '0;
            arg        <= '0;
            extra      <= '0;
            crc        <= '0;
            byte_cnt   <= '0;
            poll       <= '0;
            OutputData <= SD_IDLE_BYTE;
            SPI_Enable <= 1'b0;
            SD_CS      <= 1'b1;
            Timeout    <= 1'b0;
            Resp_R1    <= SD_IDLE_BYTE;
            Resp_Data  <= '0;
        end else begin
            state      <= state_nx;
            dclk_sync  <= {dclk_sync[SYNC_STAGES-2:0], DataClk};
            dclk_prev  <= dclk_sync[SYNC_STAGES-1];
            idx        <= idx_nx;
            arg        <= arg_nx;
            extra      <= extra_nx;
            crc        <= crc_nx;
            byte_cnt   <= byte_cnt_nx;
            poll       <= poll_nx;
            OutputData <= out_nx;
            SPI_Enable <= en_nx;
            SD_CS      <= cs_nx;
            Timeout    <= to_nx;
            Resp_R1    <= r1_nx;
            Resp_Data  <= data_nx;
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine: free-running byte shifter and scripted card around the
// command engine; MOSI bytes are scored against frames queued by each test.
module tb_sd_spi_cmd_engine;
    localparam int HALF = 12;
    localparam int SYNC = 2;
    logic        MasterCLK, Reset_n, Cmd_Start, DataClk;
    logic [5:0]  Cmd_Index;
    logic [31:0] Cmd_Arg;
    logic [2:0]  Resp_Extra;
    logic        Busy, Done, Timeout, SPI_Enable, SD_CS;
    logic [7:0]  Resp_R1, OutputData, InputData;
    logic [31:0] Resp_Data;
    logic [7:0]  exp_q[$];
    logic [7:0]  card_q[$];
    int total, bad, nbytes, done_cnt, cyc, rise_cyc;

    sd_spi_cmd_engine #(.NCR_MAX(8), .SYNC_STAGES(SYNC)) dut (
        .MasterCLK(MasterCLK), .Reset_n(Reset_n), .Cmd_Start(Cmd_Start),
        .Cmd_Index(Cmd_Index), .Cmd_Arg(Cmd_Arg), .Resp_Extra(Resp_Extra),
        .Busy(Busy), .Done(Done), .Timeout(Timeout), .Resp_R1(Resp_R1),
        .Resp_Data(Resp_Data), .OutputData(OutputData), .SPI_Enable(SPI_Enable),
        .SD_CS(SD_CS), .InputData(InputData), .DataClk(DataClk)
    );

    initial begin
        MasterCLK = 0;
        forever #5 MasterCLK = ~MasterCLK;
    end
    initial begin
        cyc = 0;
        forever begin
            @(posedge MasterCLK);
            cyc++;
        end
    end
    initial begin
        done_cnt = 0;
        forever begin
            @(negedge MasterCLK);
            if (Done) done_cnt++;
        end
    end

    // shifter: a byte starts at DataClk fall (OutputData taken) and ends at DataClk rise
    initial begin
        logic       cur_en;
        logic [7:0] cur_mosi, want;
        DataClk = 0;
        InputData = 8'hFF;
        rise_cyc = 0;
        forever begin
            repeat (HALF) @(negedge MasterCLK);
            DataClk = 0;
            cur_en = SPI_Enable && Reset_n;
            cur_mosi = OutputData;
            repeat (HALF) @(negedge MasterCLK);
            InputData = 8'hFF;
            if (cur_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mosi_extra byte%0d got=%02h want=none", nbytes, cur_mosi);
                end else begin
                    want = exp_q.pop_front();
                    if (cur_mosi !== want) begin
                        bad++;
                        $display("FAIL mosi byte%0d got=%02h want=%02h", nbytes, cur_mosi, want);
                    end
                end
                if (nbytes >= 7 && card_q.size() != 0) InputData = card_q.pop_front();
                nbytes++;
            end
            DataClk = 1;
            rise_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic expect_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb,
                                input int npoll, input int nresp);
        exp_q.push_back(8'hFF);
        exp_q.push_back({2'b01, idx});
        for (int i = 3; i >= 0; i--) exp_q.push_back(arg[8*i +: 8]);
        exp_q.push_back(crcb);
        for (int i = 0; i < npoll + nresp + 1; i++) exp_q.push_back(8'hFF);
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] extra);
        @(negedge MasterCLK);
        nbytes = 0;
        Cmd_Index = idx;
        Cmd_Arg = arg;
        Resp_Extra = extra;
        Cmd_Start = 1;
        @(negedge MasterCLK);
        Cmd_Start = 0;
    endtask

    task automatic wait_done(output bit seen, output bit dropped);
        seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge MasterCLK);
            #1;
            seen = Done;
        end
        @(posedge MasterCLK);
        #1;
        dropped = !Done;
    endtask

    task automatic test_reset;
        total += 3;
        if ({OutputData, SPI_Enable, SD_CS} !== {8'hFF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_spi got=%02h/%b/%b want=ff/0/1", OutputData, SPI_Enable, SD_CS);
        end
        if ({Busy, Done, Timeout} !== 3'b000) begin
            bad++;
            $display("FAIL reset_status got=%b%b%b want=000", Busy, Done, Timeout);
        end
        if ({Resp_R1, Resp_Data} !== {8'hFF, 32'h0}) begin
            bad++;
            $display("FAIL reset_resp got=%02h/%08h want=ff/00000000", Resp_R1, Resp_Data);
        end
    endtask

    task automatic test_cmd0;
        bit seen, dropped;
        int d0;
        d0 = done_cnt;
        expect_frame(6'd0, 32'h0, 8'h95, 2, 0);
        card_q = '{8'hFF, 8'h01};
        do_cmd(6'd0, 32'h0, 3'd0);
        total++;
        if (Busy !== 1'b1) begin bad++; $display("FAIL cmd0_busy got=%b want=1", Busy); end
        wait_done(seen, dropped);
        total += 5;
        if (!seen || !dropped) begin bad++; $display("FAIL cmd0_done got=%b%b want=11", seen, dropped); end
        if ({Timeout, Resp_R1, Resp_Data} !== {1'b0, 8'h01, 32'h0}) begin
            bad++;
            $display("FAIL cmd0_resp got=%b/%02h/%08h want=0/01/00000000", Timeout, Resp_R1, Resp_Data);
        end
        if ({SD_CS, SPI_Enable, Busy} !== 3'b100) begin
            bad++;
            $display("FAIL cmd0_idle got=%b%b%b want=100", SD_CS, SPI_Enable, Busy);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL cmd0_bytes left=%0d want=0", exp_q.size()); end
        if (done_cnt != d0 + 1) begin bad++; $display("FAIL cmd0_pulses got=%0d want=%0d", done_cnt - d0, 1); end
    endtask

    task automatic test_cmd8_r7;
        bit seen, dropped;
        expect_frame(6'd8, 32'h1AA, 8'h87, 1, 4);
        card_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        do_cmd(6'd8, 32'h1AA, 3'd4);
        wait_done(seen, dropped);
        total += 3;
        if (!seen) begin bad++; $display("FAIL cmd8_done got=0 want=1"); end
        if ({Timeout, Resp_R1, Resp_Data} !== {1'b0, 8'h01, 32'h000001AA}) begin
            bad++;
            $display("FAIL cmd8_resp got=%b/%02h/%08h want=0/01/000001aa", Timeout, Resp_R1, Resp_Data);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL cmd8_bytes left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_extra_clamp;
        bit seen, dropped;
        expect_frame(6'd8, 32'h1AA, 8'h87, 1, 4);
        card_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33};
        do_cmd(6'd8, 32'h1AA, 3'd7);
        wait_done(seen, dropped);
        card_q.delete();
        total += 3;
        if (!seen) begin bad++; $display("FAIL clamp_done got=0 want=1"); end
        if ({Resp_R1, Resp_Data} !== {8'h01, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL clamp_resp got=%02h/%08h want=01/deadbeef", Resp_R1, Resp_Data);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL clamp_bytes left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        bit seen, dropped;
        expect_frame(6'd55, 32'h0, 8'h65, 8, 0);
        card_q.delete();
        do_cmd(6'd55, 32'h0, 3'd0);
        wait_done(seen, dropped);
        total += 4;
        if (!seen) begin bad++; $display("FAIL timeout_done got=0 want=1"); end
        if ({Timeout, Resp_R1, Resp_Data} !== {1'b1, 8'hFF, 32'h0}) begin
            bad++;
            $display("FAIL timeout_resp got=%b/%02h/%08h want=1/ff/00000000", Timeout, Resp_R1, Resp_Data);
        end
        if ({SD_CS, SPI_Enable} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_cs got=%b%b want=10", SD_CS, SPI_Enable);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL timeout_bytes left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        bit seen, dropped;
        expect_frame(6'd55, 32'h0, 8'h65, 1, 0);
        card_q = '{8'h01};
        do_cmd(6'd55, 32'h0, 3'd0);
        wait_done(seen, dropped);
        total += 2;
        if (!seen) begin bad++; $display("FAIL b2b_first_done got=0 want=1"); end
        if ({Timeout, Resp_R1} !== {1'b0, 8'h01}) begin
            bad++;
            $display("FAIL b2b_first_resp got=%b/%02h want=0/01", Timeout, Resp_R1);
        end
        expect_frame(6'd41, 32'h40000000, 8'h77, 1, 1);
        card_q = '{8'h00, 8'h5A};
        do_cmd(6'd41, 32'h40000000, 3'd1);
        wait_done(seen, dropped);
        total += 3;
        if (!seen) begin bad++; $display("FAIL b2b_second_done got=0 want=1"); end
        if ({Timeout, Resp_R1, Resp_Data} !== {1'b0, 8'h00, 32'h5A000000}) begin
            bad++;
            $display("FAIL b2b_second_resp got=%b/%02h/%08h want=0/00/5a000000", Timeout, Resp_R1, Resp_Data);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_bytes left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_align_busy;
        bit seen, dropped;
        int d;
        @(negedge DataClk);
        repeat (2) @(negedge MasterCLK);
        expect_frame(6'd1, 32'h0, 8'hF9, 1, 0);
        card_q = '{8'h00};
        do_cmd(6'd1, 32'h0, 3'd0);
        Cmd_Index = 6'd55;
        Cmd_Start = 1;
        @(negedge MasterCLK);
        Cmd_Start = 0;
        total += 2;
        if ({Busy, SPI_Enable, SD_CS} !== 3'b101) begin
            bad++;
            $display("FAIL align_wait got=%b%b%b want=101", Busy, SPI_Enable, SD_CS);
        end
        for (int i = 0; i < 64 && SPI_Enable !== 1'b1; i++) begin
            @(posedge MasterCLK);
            #1;
        end
        d = cyc - rise_cyc;
        if (SPI_Enable !== 1'b1 || SD_CS !== 1'b0 || d < 2 || d > SYNC + 2) begin
            bad++;
            $display("FAIL align_edge got=en%b cs%b lag%0d want=en1 cs0 lag2..%0d", SPI_Enable, SD_CS, d, SYNC + 2);
        end
        wait_done(seen, dropped);
        repeat (50) @(negedge MasterCLK);
        total += 3;
        if (!seen || Resp_R1 !== 8'h00) begin
            bad++;
            $display("FAIL align_resp got=%b/%02h want=1/00", seen, Resp_R1);
        end
        if (Busy !== 1'b0) begin bad++; $display("FAIL busy_start_ignored got=%b want=0", Busy); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL align_bytes left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        bit seen, dropped;
        int d0;
        d0 = done_cnt;
        expect_frame(6'd0, 32'h0, 8'h95, 1, 0);
        card_q = '{8'h01};
        do_cmd(6'd0, 32'h0, 3'd0);
        for (int i = 0; i < 400 && nbytes < 3; i++) @(negedge MasterCLK);
        total += 4;
        if ({SD_CS, SPI_Enable} !== 2'b01) begin
            bad++;
            $display("FAIL mid_active got=%b%b want=01", SD_CS, SPI_Enable);
        end
        Reset_n = 0;
        #1;
        if ({SD_CS, SPI_Enable, OutputData, Busy} !== {1'b1, 1'b0, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got=%b/%b/%02h/%b want=1/0/ff/0", SD_CS, SPI_Enable, OutputData, Busy);
        end
        repeat (3) @(negedge MasterCLK);
        exp_q.delete();
        card_q.delete();
        Reset_n = 1;
        repeat (60) @(negedge MasterCLK);
        if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", done_cnt - d0); end
        if ({SD_CS, Busy} !== 2'b10) begin bad++; $display("FAIL mid_idle got=%b%b want=10", SD_CS, Busy); end
        expect_frame(6'd0, 32'h0, 8'h95, 1, 0);
        card_q = '{8'h01};
        do_cmd(6'd0, 32'h0, 3'd0);
        wait_done(seen, dropped);
        total += 2;
        if (!seen || Resp_R1 !== 8'h01) begin
            bad++;
            $display("FAIL mid_recover got=%b/%02h want=1/01", seen, Resp_R1);
        end
        if (exp_q.size() != 0) begin bad++; $display("FAIL mid_bytes left=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        nbytes = 0;
        Reset_n = 0;
        Cmd_Start = 0;
        Cmd_Index = '0;
        Cmd_Arg = '0;
        Resp_Extra = '0;
        repeat (3) @(negedge MasterCLK);
        test_reset;
        Reset_n = 1;
        repeat (5) @(negedge MasterCLK);
        test_cmd0;
        test_cmd8_r7;
        test_extra_clamp;
        test_timeout;
        test_back_to_back;
        test_align_busy;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
